// File: rtl/mips_ctrl_pkg.sv
// Shared constants and types for the multicycle MIPS control sequencer.
package mips_ctrl_pkg;

    // Opcodes (IR[31:26])
    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;

    // ALUOp codes understood by the downstream ALU control decoder
    localparam logic [2:0] ALU_ADD   = 3'b100;
    localparam logic [2:0] ALU_SUB   = 3'b001;
    localparam logic [2:0] ALU_OR    = 3'b101;
    localparam logic [2:0] ALU_AND   = 3'b110;
    localparam logic [2:0] ALU_FUNCT = 3'b111;

    // ALU operand B selects
    localparam logic [1:0] SRCB_B      = 2'b00;
    localparam logic [1:0] SRCB_FOUR   = 2'b01;
    localparam logic [1:0] SRCB_IMM    = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH = 2'b11;

    typedef enum logic [3:0] {
        S_FETCH   = 4'd0,
        S_DECODE  = 4'd1,
        S_MEM_ADR = 4'd2,
        S_MEM_RD  = 4'd3,
        S_WB_MEM  = 4'd4,
        S_MEM_WR  = 4'd5,
        S_EXEC_R  = 4'd6,
        S_WB_R    = 4'd7,
        S_EXEC_I  = 4'd8,
        S_WB_I    = 4'd9,
        S_BRANCH  = 4'd10
    } state_t;

    typedef struct packed {
        logic       pc_write;
        logic       pc_write_eq;
        logic       pc_write_ne;
        logic       i_or_d;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       mem_to_reg;
        logic       reg_dst;
        logic       reg_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [2:0] alu_op;
        logic       pc_source;
    } ctrl_t;

endpackage

// File: rtl/multicycle_ctrl_rom.sv
// Combinational control word lookup: {state, latched opcode} -> datapath strobes.
module multicycle_ctrl_rom
    import mips_ctrl_pkg::*;
(
    input  state_t     state,
    input  logic [5:0] op_q,
    output ctrl_t      ctrl
);

    // Moore decode of the control word; FETCH strobes are qualified by the top level
    always_comb begin
        ctrl = '0;
        case (state)
            S_FETCH: begin
                ctrl.mem_read  = 1'b1;
                ctrl.ir_write  = 1'b1;
                ctrl.pc_write  = 1'b1;
                ctrl.alu_src_b = SRCB_FOUR;
                ctrl.alu_op    = ALU_ADD;
            end
            S_DECODE: begin
                ctrl.alu_src_b = SRCB_IMM_SH;
                ctrl.alu_op    = ALU_ADD;
            end
            S_MEM_ADR: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_IMM;
                ctrl.alu_op    = ALU_ADD;
            end
            S_MEM_RD: begin
                ctrl.i_or_d   = 1'b1;
                ctrl.mem_read = 1'b1;
            end
            S_WB_MEM: begin
                ctrl.mem_to_reg = 1'b1;
                ctrl.reg_write  = 1'b1;
            end
            S_MEM_WR: begin
                ctrl.i_or_d    = 1'b1;
                ctrl.mem_write = 1'b1;
            end
            S_EXEC_R: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_B;
                ctrl.alu_op    = ALU_FUNCT;
            end
            S_WB_R: begin
                ctrl.reg_dst   = 1'b1;
                ctrl.reg_write = 1'b1;
            end
            S_EXEC_I: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_IMM;
                case (op_q)
                    OP_ORI:  ctrl.alu_op = ALU_OR;
                    OP_ANDI: ctrl.alu_op = ALU_AND;
                    default: ctrl.alu_op = ALU_ADD;
                endcase
            end
            S_WB_I: begin
                ctrl.reg_write = 1'b1;
            end
            S_BRANCH: begin
                ctrl.alu_src_a   = 1'b1;
                ctrl.alu_src_b   = SRCB_B;
                ctrl.alu_op      = ALU_SUB;
                ctrl.pc_source   = 1'b1;
                ctrl.pc_write_eq = (op_q == OP_BEQ);
                ctrl.pc_write_ne = (op_q == OP_BNE);
            end
            default: ctrl = '0;
        endcase
    end

endmodule

// File: rtl/multicycle_control.sv
// Multicycle MIPS control sequencer: state register, opcode latch, next-state
// logic, memory-ready qualification and reset masking of all strobes.
module multicycle_control
    import mips_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] op,
    input  logic       mem_ready,
    output logic       pc_write,
    output logic       pc_write_eq,
    output logic       pc_write_ne,
    output logic       i_or_d,
    output logic       mem_read,
    output logic       mem_write,
    output logic       ir_write,
    output logic       mem_to_reg,
    output logic       reg_dst,
    output logic       reg_write,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [2:0] alu_op,
    output logic       pc_source,
    output logic [3:0] state_o,
    output logic       illegal_op
);

    state_t     state;
    state_t     next_state;
    logic [5:0] op_q;
    logic       illegal;
    ctrl_t      rom_ctrl;
    ctrl_t      ctrl;

    multicycle_ctrl_rom u_rom (
        .state (state),
        .op_q  (op_q),
        .ctrl  (rom_ctrl)
    );

    // State register and opcode latch; op is captured as DECODE completes
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_FETCH;
            op_q  <= '0;
        end else begin
            state <= next_state;
            if (state == S_DECODE) begin
                op_q <= op;
            end
        end
    end

    // Next-state selection; DECODE dispatches on the live op, later states on op_q
    always_comb begin
        next_state = state;
        illegal    = 1'b0;
        case (state)
            S_FETCH:   if (mem_ready) next_state = S_DECODE;
            S_DECODE: begin
                case (op)
                    OP_RTYPE:                  next_state = S_EXEC_R;
                    OP_ADDI, OP_ORI, OP_ANDI:  next_state = S_EXEC_I;
                    OP_LW, OP_SW:              next_state = S_MEM_ADR;
                    OP_BEQ, OP_BNE:            next_state = S_BRANCH;
                    default: begin
                        next_state = S_FETCH;
                        illegal    = 1'b1;
                    end
                endcase
            end
            S_MEM_ADR: next_state = (op_q == OP_LW) ? S_MEM_RD : S_MEM_WR;
            S_MEM_RD:  if (mem_ready) next_state = S_WB_MEM;
            S_WB_MEM:  next_state = S_FETCH;
            S_MEM_WR:  if (mem_ready) next_state = S_FETCH;
            S_EXEC_R:  next_state = S_WB_R;
            S_WB_R:    next_state = S_FETCH;
            S_EXEC_I:  next_state = S_WB_I;
            S_WB_I:    next_state = S_FETCH;
            S_BRANCH:  next_state = S_FETCH;
            default:   next_state = S_FETCH;
        endcase
    end

    // IR/PC load in FETCH only when memory delivers; everything is silenced during reset
    always_comb begin
        ctrl = rom_ctrl;
        if (state == S_FETCH) begin
            ctrl.ir_write = rom_ctrl.ir_write & mem_ready;
            ctrl.pc_write = rom_ctrl.pc_write & mem_ready;
        end
        if (reset) begin
            ctrl = '0;
        end
    end

    assign pc_write    = ctrl.pc_write;
    assign pc_write_eq = ctrl.pc_write_eq;
    assign pc_write_ne = ctrl.pc_write_ne;
    assign i_or_d      = ctrl.i_or_d;
    assign mem_read    = ctrl.mem_read;
    assign mem_write   = ctrl.mem_write;
    assign ir_write    = ctrl.ir_write;
    assign mem_to_reg  = ctrl.mem_to_reg;
    assign reg_dst     = ctrl.reg_dst;
    assign reg_write   = ctrl.reg_write;
    assign alu_src_a   = ctrl.alu_src_a;
    assign alu_src_b   = ctrl.alu_src_b;
    assign alu_op      = ctrl.alu_op;
    assign pc_source   = ctrl.pc_source;
    assign state_o     = state;
    assign illegal_op  = illegal & ~reset;

endmodule

// File: tb/tb_multicycle_control.sv
// Directed testbench for multicycle_control with hand-computed control words.
module tb_multicycle_control;

    logic       clk = 1'b0;
    logic       reset;
    logic [5:0] op;
    logic       mem_ready;
    logic       pc_write, pc_write_eq, pc_write_ne, i_or_d, mem_read, mem_write;
    logic       ir_write, mem_to_reg, reg_dst, reg_write, alu_src_a, pc_source;
    logic [1:0] alu_src_b;
    logic [2:0] alu_op;
    logic [3:0] state_o;
    logic       illegal_op;

    int unsigned tests = 0;
    int unsigned fails = 0;

    // Field order: pcw pceq pcne | iord mrd mwr | irw m2r rdst | rwr srcA | srcB | aluop | pcsrc ill
    logic [17:0] cw;
    assign cw = {pc_write, pc_write_eq, pc_write_ne, i_or_d, mem_read, mem_write,
                 ir_write, mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b,
                 alu_op, pc_source, illegal_op};

    localparam logic [17:0] CW_ZERO     = 18'b000_000_000_00_00_000_00;
    localparam logic [17:0] CW_FETCH    = 18'b100_010_100_00_01_100_00;
    localparam logic [17:0] CW_FETCH_W  = 18'b000_010_000_00_01_100_00;
    localparam logic [17:0] CW_DEC      = 18'b000_000_000_00_11_100_00;
    localparam logic [17:0] CW_DEC_ILL  = 18'b000_000_000_00_11_100_01;
    localparam logic [17:0] CW_EXEC_R   = 18'b000_000_000_01_00_111_00;
    localparam logic [17:0] CW_WB_R     = 18'b000_000_001_10_00_000_00;
    localparam logic [17:0] CW_ADDI     = 18'b000_000_000_01_10_100_00;
    localparam logic [17:0] CW_ORI      = 18'b000_000_000_01_10_101_00;
    localparam logic [17:0] CW_ANDI     = 18'b000_000_000_01_10_110_00;
    localparam logic [17:0] CW_WB_I     = 18'b000_000_000_10_00_000_00;
    localparam logic [17:0] CW_MEM_ADR  = 18'b000_000_000_01_10_100_00;
    localparam logic [17:0] CW_MEM_RD   = 18'b000_110_000_00_00_000_00;
    localparam logic [17:0] CW_WB_MEM   = 18'b000_000_010_10_00_000_00;
    localparam logic [17:0] CW_MEM_WR   = 18'b000_101_000_00_00_000_00;
    localparam logic [17:0] CW_BEQ      = 18'b010_000_000_01_00_001_10;
    localparam logic [17:0] CW_BNE      = 18'b001_000_000_01_00_001_10;

    multicycle_control dut (
        .clk         (clk),
        .reset       (reset),
        .op          (op),
        .mem_ready   (mem_ready),
        .pc_write    (pc_write),
        .pc_write_eq (pc_write_eq),
        .pc_write_ne (pc_write_ne),
        .i_or_d      (i_or_d),
        .mem_read    (mem_read),
        .mem_write   (mem_write),
        .ir_write    (ir_write),
        .mem_to_reg  (mem_to_reg),
        .reg_dst     (reg_dst),
        .reg_write   (reg_write),
        .alu_src_a   (alu_src_a),
        .alu_src_b   (alu_src_b),
        .alu_op      (alu_op),
        .pc_source   (pc_source),
        .state_o     (state_o),
        .illegal_op  (illegal_op)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s at %0t: got=%0h expected=%0h", tag, $time, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Inputs are set just after an edge; outputs are checked 1 time unit later, then advance
    task automatic step(input string tag, input logic [3:0] st, input logic [17:0] exp_cw);
        #1;
        check({tag, "_state"}, {28'd0, state_o}, {28'd0, st});
        check({tag, "_cw"}, {14'd0, cw}, {14'd0, exp_cw});
        tick();
    endtask

    initial begin
        reset     = 1'b1;
        op        = 6'h00;
        mem_ready = 1'b1;

        // Reset held two cycles
        tick();
        check("rst_cyc1_cw", {14'd0, cw}, {14'd0, CW_ZERO});
        tick();
        check("rst_cyc2_cw", {14'd0, cw}, {14'd0, CW_ZERO});
        check("rst_state", {28'd0, state_o}, 32'd0);
        reset = 1'b0;

        // ADD: 0,1,6,7 then FETCH
        op = 6'h00;
        step("add_fetch", 4'd0, CW_FETCH);
        step("add_dec",   4'd1, CW_DEC);
        op = 6'h08;       // changing op after DECODE must not matter
        step("add_exec",  4'd6, CW_EXEC_R);
        step("add_wb",    4'd7, CW_WB_R);

        // FETCH stall, then LW with a three-cycle memory wait
        mem_ready = 1'b0;
        op = 6'h23;
        step("lw_fwait",  4'd0, CW_FETCH_W);
        mem_ready = 1'b1;
        step("lw_fetch",  4'd0, CW_FETCH);
        step("lw_dec",    4'd1, CW_DEC);
        op = 6'h2B;       // path already fixed as LW
        step("lw_adr",    4'd2, CW_MEM_ADR);
        mem_ready = 1'b0;
        step("lw_rd0",    4'd3, CW_MEM_RD);
        step("lw_rd1",    4'd3, CW_MEM_RD);
        step("lw_rd2",    4'd3, CW_MEM_RD);
        mem_ready = 1'b1;
        step("lw_rd3",    4'd3, CW_MEM_RD);
        step("lw_wb",     4'd4, CW_WB_MEM);

        // ADDI / ORI / ANDI
        op = 6'h08;
        step("addi_fetch", 4'd0, CW_FETCH);
        step("addi_dec",   4'd1, CW_DEC);
        step("addi_exec",  4'd8, CW_ADDI);
        step("addi_wb",    4'd9, CW_WB_I);
        op = 6'h0D;
        step("ori_fetch",  4'd0, CW_FETCH);
        step("ori_dec",    4'd1, CW_DEC);
        op = 6'h0C;       // latched ORI must drive alu_op
        step("ori_exec",   4'd8, CW_ORI);
        step("ori_wb",     4'd9, CW_WB_I);
        op = 6'h0C;
        step("andi_fetch", 4'd0, CW_FETCH);
        step("andi_dec",   4'd1, CW_DEC);
        step("andi_exec",  4'd8, CW_ANDI);
        step("andi_wb",    4'd9, CW_WB_I);

        // BNE then BEQ (op changed during BRANCH for BEQ)
        op = 6'h05;
        step("bne_fetch", 4'd0, CW_FETCH);
        step("bne_dec",   4'd1, CW_DEC);
        step("bne_br",    4'd10, CW_BNE);
        op = 6'h04;
        step("beq_fetch", 4'd0, CW_FETCH);
        step("beq_dec",   4'd1, CW_DEC);
        op = 6'h05;
        step("beq_br",    4'd10, CW_BEQ);

        // Illegal opcode: one-cycle pulse in DECODE, back to FETCH
        op = 6'h3F;
        step("ill_fetch", 4'd0, CW_FETCH);
        step("ill_dec",   4'd1, CW_DEC_ILL);
        step("ill_after", 4'd0, CW_FETCH);
        step("ill_dec2",  4'd1, CW_DEC_ILL);

        // SW with reset asserted while stalled in MEM_WR
        op = 6'h2B;
        step("sw_fetch",  4'd0, CW_FETCH);
        step("sw_dec",    4'd1, CW_DEC);
        op = 6'h23;       // path already fixed as SW
        step("sw_adr",    4'd2, CW_MEM_ADR);
        mem_ready = 1'b0;
        step("sw_wr",     4'd5, CW_MEM_WR);
        reset = 1'b1;
        step("sw_rst",    4'd5, CW_ZERO);
        mem_ready = 1'b1;
        step("sw_rst2",   4'd0, CW_ZERO);
        reset = 1'b0;
        step("sw_resume", 4'd0, CW_FETCH);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
